// File: rtl/types_apb_bus_ctrl_pkg.sv
// Shared types and constants for the APB interconnect and its address decoder.
package types_apb_bus_ctrl_pkg;

  // Register fields are sized for the largest legal build (NSLV up to 32).
  localparam int          IDX_W     = 6;
  localparam int          TMO_W     = 32;
  localparam logic [31:0] TMO_RDATA = 32'hDEADBEEF;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_in_type;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_out_type;

  typedef struct packed {
    logic [63:0] addr_start;
    logic [63:0] addr_end;
  } mapinfo_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_type;

  typedef struct packed {
    state_type         state;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       paddr;
    logic [2:0]        pprot;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       rdata;
    logic              err;
    logic [TMO_W-1:0]  tmo_cnt;
  } regs_type;

  localparam regs_type REGS_RESET = '0;

endpackage

// File: rtl/apb_addr_decoder.sv
// Address map decoder: returns the lowest-numbered slave whose [start, end) range
// contains the address, or NSLV with miss set when no range matches.
module apb_addr_decoder
  import types_apb_bus_ctrl_pkg::*;
#(
  parameter int                       NSLV = 8,
  parameter mapinfo_type [0:NSLV-1]   MAP  = '0
) (
  input  logic [31:0]                 paddr_i,
  output logic [$clog2(NSLV+1)-1:0]   idx_o,
  output logic                        miss_o
);

  localparam int IW = $clog2(NSLV+1);

  logic [63:0] addr64;

  assign addr64 = {32'd0, paddr_i};

  // Scanning downwards lets the lowest matching index overwrite any higher one.
  always_comb begin
    idx_o  = IW'(NSLV);
    miss_o = 1'b1;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((MAP[i].addr_start <= addr64) && (addr64 < MAP[i].addr_end)) begin
        idx_o  = IW'(i);
        miss_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_bus_ctrl.sv
// APB interconnect: one upstream master fanned out to NSLV slaves via an address map.
// Optional ACCESS watchdog enabled by defining APB_BUS_CTRL_TIMEOUT_EN.
module apb_bus_ctrl
  import types_apb_bus_ctrl_pkg::*;
#(
  parameter int                       NSLV       = 8,
  parameter mapinfo_type [0:NSLV-1]   MAP        = '0,
  parameter int                       TMO_CYCLES = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_nrst,
  input  apb_in_type                  i_mapbi,
  output apb_out_type                 o_mapbo,
  output apb_in_type                  o_slvi [0:NSLV-1],
  input  apb_out_type                 i_slvo [0:NSLV-1],
  output logic [$clog2(NSLV+1)-1:0]   o_sel_idx,
  output logic                        o_tmo
);

  localparam int IW = $clog2(NSLV+1);

`ifdef APB_BUS_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  regs_type     r_q;
  regs_type     r_d;
  logic [IW-1:0] dec_idx;
  logic         dec_miss;
  apb_out_type  sel_rsp;
  logic         tmo_limit;

  apb_addr_decoder #(
    .NSLV (NSLV),
    .MAP  (MAP)
  ) u_dec (
    .paddr_i (i_mapbi.paddr),
    .idx_o   (dec_idx),
    .miss_o  (dec_miss)
  );

  // Only the registered slave's response is ever looked at.
  always_comb begin
    sel_rsp = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_q.idx == IDX_W'(i)) begin
        sel_rsp = i_slvo[i];
      end
    end
  end

  assign tmo_limit = TMO_EN && (r_q.state == ACCESS) && !sel_rsp.pready
                     && (r_q.tmo_cnt == TMO_W'(TMO_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_q <= REGS_RESET;
    end else begin
      r_q <= r_d;
    end
  end

  always_comb begin
    r_d = r_q;
    case (r_q.state)
      IDLE: begin
        if (i_mapbi.pselx && !i_mapbi.penable) begin
          r_d.paddr  = i_mapbi.paddr;
          r_d.pprot  = i_mapbi.pprot;
          r_d.pwrite = i_mapbi.pwrite;
          r_d.pwdata = i_mapbi.pwdata;
          r_d.pstrb  = i_mapbi.pstrb;
          r_d.idx    = IDX_W'(dec_idx);
          r_d.rdata  = '0;
          r_d.err    = dec_miss;
          r_d.state  = dec_miss ? RESP : SETUP;
        end
      end
      SETUP: begin
        r_d.tmo_cnt = '0;
        r_d.state   = ACCESS;
      end
      ACCESS: begin
        // A ready slave takes priority over an expiring watchdog in the same cycle.
        if (sel_rsp.pready) begin
          r_d.rdata = sel_rsp.prdata;
          r_d.err   = sel_rsp.pslverr;
          r_d.state = RESP;
        end else if (tmo_limit) begin
          r_d.rdata = TMO_RDATA;
          r_d.err   = 1'b1;
          r_d.state = RESP;
        end else if (TMO_EN) begin
          r_d.tmo_cnt = r_q.tmo_cnt + TMO_W'(1);
        end
      end
      RESP: begin
        r_d.state = IDLE;
      end
      default: begin
        r_d.state = IDLE;
      end
    endcase
  end

  always_comb begin
    o_mapbo   = '0;
    o_sel_idx = IW'(NSLV);
    o_tmo     = tmo_limit;
    for (int i = 0; i < NSLV; i++) begin
      o_slvi[i] = '0;
    end
    if (r_q.state != IDLE) begin
      o_sel_idx = r_q.idx[IW-1:0];
    end
    if (r_q.state == RESP) begin
      o_mapbo.pready  = 1'b1;
      o_mapbo.prdata  = r_q.rdata;
      o_mapbo.pslverr = r_q.err;
    end
    if ((r_q.state == SETUP) || (r_q.state == ACCESS)) begin
      for (int i = 0; i < NSLV; i++) begin
        if (r_q.idx == IDX_W'(i)) begin
          o_slvi[i] = '{paddr:   r_q.paddr,
                        pprot:   r_q.pprot,
                        pselx:   1'b1,
                        penable: (r_q.state == ACCESS),
                        pwrite:  r_q.pwrite,
                        pwdata:  r_q.pwdata,
                        pstrb:   r_q.pstrb};
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_bus_ctrl.sv
// Self-checking bench for apb_bus_ctrl: directed scenarios plus randomized transfers
// compared against a decode/latency model derived from the address map rules.
`timescale 1ns/1ps
module tb_apb_bus_ctrl;
  import types_apb_bus_ctrl_pkg::*;

  localparam int NSLV   = 8;
  localparam int IW     = $clog2(NSLV+1);
  localparam int TB_TMO = 16;

  // Slave 2 overlaps slave 1, slave 6 is an empty range, 0x20000 is unmapped.
  localparam mapinfo_type [0:NSLV-1] TB_MAP = {
    {64'h0001_0000, 64'h0001_1000},
    {64'h0001_2000, 64'h0001_3000},
    {64'h0001_1000, 64'h0001_4000},
    {64'h0005_2000, 64'h0005_3000},
    {64'h0003_0000, 64'h0003_1000},
    {64'h0004_0000, 64'h0004_1000},
    {64'h0006_0000, 64'h0006_0000},
    {64'h0007_0000, 64'h0008_0000}
  };

`ifdef APB_BUS_CTRL_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic          clk;
  logic          nrst;
  apb_in_type    mreq;
  apb_out_type   mrsp;
  apb_in_type    slvi [0:NSLV-1];
  apb_out_type   slvo [0:NSLV-1];
  logic [IW-1:0] selIdx;
  logic          tmo;

  int checks   = 0;
  int failures = 0;

  apb_bus_ctrl #(
    .NSLV       (NSLV),
    .MAP        (TB_MAP),
    .TMO_CYCLES (TB_TMO)
  ) dut (
    .i_clk     (clk),
    .i_nrst    (nrst),
    .i_mapbi   (mreq),
    .o_mapbo   (mrsp),
    .o_slvi    (slvi),
    .i_slvo    (slvo),
    .o_sel_idx (selIdx),
    .o_tmo     (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: first map entry whose half-open range holds the address.
  function automatic int model_decode(input logic [31:0] addr);
    longint unsigned a;
    a = {32'd0, addr};
    for (int i = 0; i < NSLV; i++) begin
      if (a >= TB_MAP[i].addr_start && a < TB_MAP[i].addr_end) return i;
    end
    return -1;
  endfunction

  task automatic clear_slaves();
    for (int j = 0; j < NSLV; j++) slvo[j] = '0;
  endtask

  // One full upstream transfer; the bench plays every slave. waits<0 = never ready.
  // Called at #1 after a rising edge; returns at #1 after the completion edge.
  task automatic do_xfer(input string tag, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb, input int waits,
                         input logic [31:0] srd, input logic serr, input logic scramble);
    int          t, expL, cyc, gotL, tmoCyc;
    logic [31:0] expRd, gotRd;
    logic        expErr, gotErr, busBad, selBad, tmoBad, done;
    logic [2:0]  prot;
    apb_in_type  expAct, e;
    t    = model_decode(addr);
    prot = 3'($urandom_range(0, 7));
    if (t < 0) begin
      expL = 1; expRd = 32'd0; expErr = 1'b1;
    end else if (waits < 0) begin
      expL = 2 + TB_TMO; expRd = 32'hDEADBEEF; expErr = 1'b1;
    end else begin
      expL = 3 + waits; expRd = srd; expErr = serr;
    end
    tmoCyc = (t >= 0 && waits < 0) ? 1 + TB_TMO : -1;
    expAct = '{paddr: addr, pprot: prot, pselx: 1'b1, penable: 1'b0,
               pwrite: wr, pwdata: wdata, pstrb: strb};
    mreq = expAct;
    @(posedge clk); #1;
    mreq.penable = 1'b1;
    if (scramble) begin
      mreq.paddr  = $urandom;
      mreq.pwdata = $urandom;
      mreq.pwrite = ~wr;
      mreq.pstrb  = ~strb;
      mreq.pprot  = ~prot;
    end
    cyc = 0; done = 1'b0; busBad = 1'b0; selBad = 1'b0; tmoBad = 1'b0;
    gotL = -1; gotRd = '0; gotErr = 1'b0;
    while (!done && cyc < 64) begin
      cyc++;
      @(negedge clk);
      for (int j = 0; j < NSLV; j++) begin
        e = '0;
        if (j == t && cyc < expL) begin
          e = expAct;
          e.penable = (cyc >= 2);
        end
        if (slvi[j] !== e) busBad = 1'b1;
      end
      if (t >= 0 && cyc < expL && selIdx !== IW'(t)) selBad = 1'b1;
      if (t < 0 && cyc == 1 && selIdx !== IW'(NSLV)) selBad = 1'b1;
      if (tmo !== (cyc == tmoCyc)) tmoBad = 1'b1;
      if (mrsp.pready === 1'b1) begin
        gotL = cyc; gotRd = mrsp.prdata; gotErr = mrsp.pslverr; done = 1'b1;
      end
      // Non-target slaves chatter randomly; only the target's answer may matter.
      for (int j = 0; j < NSLV; j++) begin
        if (j == t) begin
          if (waits >= 0 && cyc == 2 + waits)
            slvo[j] = '{pready: 1'b1, prdata: srd, pslverr: serr};
          else
            slvo[j] = '{pready: 1'b0, prdata: $urandom, pslverr: 1'($urandom_range(0, 1))};
        end else begin
          slvo[j] = '{pready: 1'($urandom_range(0, 1)), prdata: $urandom,
                      pslverr: 1'($urandom_range(0, 1))};
        end
      end
      @(posedge clk); #1;
    end
    mreq = '0;
    clear_slaves();
    checks++;
    if (gotL !== expL) begin
      failures++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", tag, gotL, expL);
    end
    checks++;
    if (gotRd !== expRd) begin
      failures++;
      $display("[TB] FAIL %s prdata: got %h expected %h", tag, gotRd, expRd);
    end
    checks++;
    if (gotErr !== expErr) begin
      failures++;
      $display("[TB] FAIL %s pslverr: got %b expected %b", tag, gotErr, expErr);
    end
    checks++;
    if (busBad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s slave_bus: got wrong downstream request, expected only slave %0d active", tag, t);
    end
    checks++;
    if (selBad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s sel_idx: got wrong index, expected %0d", tag, (t < 0) ? NSLV : t);
    end
    checks++;
    if (tmoBad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s o_tmo: got bad pulse, expected pulse at cycle %0d", tag, tmoCyc);
    end
  endtask

  task automatic test_reset();
    logic bad;
    nrst = 1'b1;
    mreq = '0;
    clear_slaves();
    #2 nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bad = 1'b0;
    for (int j = 0; j < NSLV; j++) if (slvi[j] !== '0) bad = 1'b1;
    checks++;
    if (mrsp !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mapbo: got %h expected 0", mrsp);
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_slvi: got nonzero slave request expected all zero");
    end
    checks++;
    if (selIdx !== IW'(NSLV) || tmo !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idx_tmo: got idx=%0d tmo=%b expected idx=%0d tmo=0", selIdx, tmo, NSLV);
    end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_xfer("read_s0", 32'h0001_0004, 1'b0, 32'd0, 4'hF, 0, 32'h1234_5678, 1'b0, 1'b0);
    do_xfer("write_s3", 32'h0005_2008, 1'b1, 32'h0000_00A5, 4'h5, 2, 32'h0, 1'b0, 1'b0);
    do_xfer("unmapped", 32'h0002_0000, 1'b0, 32'd0, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_xfer("overlap", 32'h0001_2000, 1'b0, 32'd0, 4'hF, 1, 32'hCAFE_0001, 1'b0, 1'b0);
  endtask

  task automatic test_decode_bounds();
    do_xfer("last_s0", 32'h0001_0FFF, 1'b0, 32'd0, 4'hF, 0, $urandom, 1'b1, 1'b0);
    do_xfer("first_s2", 32'h0001_1000, 1'b1, $urandom, 4'h3, 0, $urandom, 1'b0, 1'b0);
    do_xfer("last_s7", 32'h0007_FFFC, 1'b0, 32'd0, 4'hF, 3, $urandom, 1'b0, 1'b0);
    do_xfer("end_s7", 32'h0008_0000, 1'b0, 32'd0, 4'hF, 0, $urandom, 1'b0, 1'b0);
    do_xfer("empty_s6", 32'h0006_0000, 1'b0, 32'd0, 4'hF, 0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic test_idle_penable();
    logic bad;
    bad = 1'b0;
    mreq = '{paddr: 32'h0001_0010, pprot: 3'd0, pselx: 1'b1, penable: 1'b1,
             pwrite: 1'b0, pwdata: 32'd0, pstrb: 4'hF};
    repeat (3) begin
      @(negedge clk);
      if (mrsp.pready !== 1'b0 || selIdx !== IW'(NSLV)) bad = 1'b1;
      for (int j = 0; j < NSLV; j++) if (slvi[j] !== '0) bad = 1'b1;
    end
    @(posedge clk); #1;
    mreq = '0;
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_penable: got activity expected request ignored");
    end
  endtask

  // Transfers issued with no idle cycle between them, upstream fields scrambled after setup.
  task automatic test_back_to_back();
    do_xfer("b2b_a", 32'h0003_0100, 1'b1, $urandom, 4'hC, 1, $urandom, 1'b0, 1'b1);
    do_xfer("b2b_b", 32'h0002_0010, 1'b0, 32'd0, 4'hF, 0, $urandom, 1'b0, 1'b1);
    do_xfer("b2b_c", 32'h0004_0200, 1'b0, 32'd0, 4'hF, 0, $urandom, 1'b1, 1'b1);
    do_xfer("b2b_d", 32'h0001_2FF0, 1'b1, $urandom, 4'h1, 2, $urandom, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic bad;
    mreq = '{paddr: 32'h0003_0040, pprot: 3'd2, pselx: 1'b1, penable: 1'b0,
             pwrite: 1'b0, pwdata: 32'd0, pstrb: 4'hF};
    clear_slaves();
    @(posedge clk); #1;
    mreq.penable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (slvi[4].pselx !== 1'b1 || slvi[4].penable !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_access: got psel=%b penable=%b expected 1 1", slvi[4].pselx, slvi[4].penable);
    end
    #2 nrst = 1'b0;
    #1;
    bad = 1'b0;
    for (int j = 0; j < NSLV; j++) if (slvi[j] !== '0) bad = 1'b1;
    if (mrsp !== '0 || selIdx !== IW'(NSLV) || tmo !== 1'b0) bad = 1'b1;
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset: got outputs active expected all cleared immediately");
    end
    mreq = '0;
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
    do_xfer("after_reset", 32'h0003_0040, 1'b0, 32'd0, 4'hF, 1, 32'h0BAD_F00D, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    if (TMO_ON) begin
      do_xfer("tmo_s5", 32'h0004_0010, 1'b0, 32'd0, 4'hF, -1, 32'd0, 1'b0, 1'b0);
      do_xfer("tmo_next", 32'h0001_0020, 1'b0, 32'd0, 4'hF, 0, 32'h5555_AAAA, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    int          k, gap;
    logic [31:0] addr;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      if (k < NSLV)
        addr = (TB_MAP[k].addr_start[31:0] + 32'($urandom_range(0, 4095))) & ~32'h3;
      else if (k == 8)
        addr = 32'h0002_0000 + 32'($urandom_range(0, 4095));
      else
        addr = $urandom;
      do_xfer("random", addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_decode_bounds();
    test_idle_penable();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_watchdog: got no completion expected finish before 200us");
    $fatal(1, "[TB] stopped by watchdog");
  end

endmodule

// File: doc/apb_bus_ctrl.md
Name: apb_bus_ctrl

Overview:
- Parametrised APB interconnect: one upstream APB master port fanned out to NSLV downstream APB slaves.
- Decodes each transfer against a per-instance address map parameter.
- Registers the selected slave, sequences the downstream SETUP/ACCESS phases and returns the response upstream.
- Unmapped addresses get an error response. With the optional feature, a watchdog aborts hung slaves.
- Replaces hand-written per-bus decode logic for Bus[1] and later buses.

Parameters:
NSLV, 8, number of downstream APB slaves (1..32).
MAP, all-zero mapinfo_type[0:NSLV-1], per-slave {addr_start, addr_end}; instantiator overrides.
TMO_CYCLES, 1024, ACCESS-phase cycle limit before abort (only with APB_BUS_CTRL_TIMEOUT_EN).

Ports:
i_clk  in  1  clock
i_nrst  in  1  async reset, active low
i_mapbi  in  apb_in_type  upstream request (paddr, pprot, pselx, penable, pwrite, pwdata, pstrb)
o_mapbo  out  apb_out_type  upstream response (pready, prdata, pslverr)
o_slvi  out  apb_in_type[0:NSLV-1]  downstream requests
i_slvo  in  apb_out_type[0:NSLV-1]  downstream responses
o_sel_idx  out  $clog2(NSLV+1)  index of the active slave; NSLV = none or miss (debug)
o_tmo  out  1  one-cycle pulse on watchdog abort (tied 0 without feature)

Behaviour:
- Reset (async, i_nrst=0):
  - state=IDLE; all registers zero.
  - o_mapbo={pready 0, prdata 0, pslverr 0}; every o_slvi zero; o_sel_idx=NSLV; o_tmo=0.
  - Reset mid-transfer abandons it immediately; the slave sees psel drop.
- Decode (combinational, IDLE only):
  - hit[i] = MAP[i].addr_start <= zext64(paddr) < MAP[i].addr_end.
  - Lowest hit index wins; no hit means miss.
  - An empty range (start>=end) never hits.
- FSM:
  - IDLE: on pselx=1 && penable=0, latch paddr/pwrite/pwdata/pstrb/pprot and the index. A hit goes to SETUP; a miss goes to RESP with err=1, rdata=0. A request with penable=1 in IDLE is ignored (mid-transfer of an already-answered access).
  - SETUP (1 cycle): o_slvi[idx].pselx=1, penable=0, latched fields driven. Next state is ACCESS.
  - ACCESS: o_slvi[idx].pselx=1, penable=1. On i_slvo[idx].pready=1, latch prdata and pslverr, drop pselx the next cycle, go to RESP.
  - RESP (1 cycle): o_mapbo.pready=1 with latched prdata/pslverr. Next state is IDLE.
- Non-selected slaves always see pselx=0 and penable=0. Only the selected slave gets the address, data and strobe fields.
- Latency, first pready at the master, counted from the master setup edge: hit = 3 + slave wait states; miss = 1.
- The master must hold its request until pready. Back-to-back transfers (psel held high, new setup with penable=0 the cycle after pready) are accepted with no idle gap beyond RESP.
- Upstream request changes after the IDLE latch are ignored until RESP.
- pready from an unselected slave is ignored.

Optional Feature:
APB_BUS_CTRL_TIMEOUT_EN
- Defined:
  - A counter ($clog2(TMO_CYCLES+1) bits) clears on entry to ACCESS and increments each ACCESS cycle without pready.
  - When it reaches TMO_CYCLES: deassert the slave select, pulse o_tmo, go to RESP with pslverr=1, prdata=32'hDEADBEEF.
  - If pready and the limit occur in the same cycle, pready wins.
- Not defined: ACCESS waits indefinitely; o_tmo is tied 0; TMO_CYCLES is unused.

Decomposition:
- Package types_apb_bus_ctrl_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - registered struct (state, idx, req fields, rdata, err, tmo_cnt);
  - reset constant;
  - TMO response constant 32'hDEADBEEF.
- One sub-module: apb_addr_decoder (parameters NSLV, MAP; in paddr; out idx, miss). It is reused by the planned AXI-lite variant.

Test Plan:
- Read 0x00010004, slave 0 pready after 0 wait states returning 0x12345678 -> o_slvi[0] setup then access; master pready at cycle 3 with prdata=0x12345678, pslverr=0; other slaves untouched.
- Write 0x00052008 data 0xA5, slave 3 inserts 2 wait states -> slave 3 sees pwdata=0xA5, pstrb passed through; master pready at cycle 5.
- Access 0x00020000 (unmapped) -> pready at cycle 1, pslverr=1, prdata=0; no slave selected; o_sel_idx=NSLV.
- Overlapping MAP entries 1 and 2 both covering 0x12000 -> slave 1 selected only.
- Feature on, TMO_CYCLES=16, slave 5 never ready -> o_tmo pulse after 16 ACCESS cycles; pslverr=1, prdata=0xDEADBEEF; then a back-to-back read to slave 0 completes normally.
- Assert i_nrst=0 during ACCESS -> all outputs zero asynchronously; after release, state is IDLE and a fresh read completes.
